coor_update_engine: RTL and testbench

Sequential successor to the single-record coordinate mux. It walks every object slot of the coordinate memory in one pass. For each slot it reads the `{x, y, opcode}` record, moves the object one step along the direction encoded in its opcode, and writes the record back. An object that leaves the field is either wrapped to the opposite edge or respawned from the random generator, depending on `COOR_WRAP_EN`. The block sits between the game-tick controller, which issues `start`, and the synchronous coordinate RAM.

---
 rtl/coor_update_engine.sv | 110 +++++++++++
 tb/tb_coor_update_engine.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/coor_update_engine.sv
// Walks every coordinate-memory slot once per start: read, step along opcode direction, write back.
// Optional macro COOR_WRAP_EN: edge crossings wrap modulo 2^N instead of respawning from the random inputs.
module coor_update_engine #(
  parameter int N     = 4,
  parameter int OPW   = 2,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int W    = 2*N + OPW
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic [N-1:0]   step,
  input  logic [N-1:0]   random_x,
  input  logic [N-1:0]   random_y,
  input  logic [OPW-1:0] random_opcode,
  input  logic [W-1:0]   mem_rd_data,
  output logic [AW-1:0]  mem_addr,
  output logic           mem_rd_en,
  output logic           mem_wr_en,
  output logic [W-1:0]   mem_wr_data,
  output logic           busy,
  output logic           done,
  output logic [AW:0]    respawn_cnt
);

  typedef struct packed {
    logic [N-1:0]   x;
    logic [N-1:0]   y;
    logic [OPW-1:0] op;
  } rec_t;

  typedef enum logic [2:0] {IDLE, READ, LATCH, WRITE, DONE} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  i_q;
  logic [N-1:0]   step_q;
  rec_t           rec_q;
  rec_t           upd, new_rec;
  logic [N-1:0]   coord;
  logic [N:0]     arith;
  logic           is_add, respawn_now;
  logic           last_slot;

  assign last_slot = (i_q == AW'(DEPTH-1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      i_q         <= '0;
      step_q      <= '0;
      rec_q       <= '0;
      respawn_cnt <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          step_q      <= step;
          i_q         <= '0;
          respawn_cnt <= '0;
        end
        LATCH: rec_q <= rec_t'(mem_rd_data);
        WRITE: begin
          if (respawn_now) respawn_cnt <= respawn_cnt + 1'b1;
          if (!last_slot) i_q <= i_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    state_d = LATCH;
      LATCH:   state_d = WRITE;
      WRITE:   state_d = last_slot ? DONE : READ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Odd opcodes move along x; 01/10 are the increasing directions.
  // Bit N of the widened result is the carry on add and the borrow on subtract.
  always_comb begin
    is_add = rec_q.op[1] ^ rec_q.op[0];
    coord  = rec_q.op[0] ? rec_q.x : rec_q.y;
    arith  = is_add ? ({1'b0, coord} + {1'b0, step_q})
                    : ({1'b0, coord} - {1'b0, step_q});
    upd    = rec_q;
    if (rec_q.op[0]) upd.x = arith[N-1:0];
    else             upd.y = arith[N-1:0];
`ifdef COOR_WRAP_EN
    respawn_now = 1'b0;
    new_rec     = upd;
`else
    respawn_now = (state_q == WRITE) && arith[N];
    new_rec     = arith[N] ? rec_t'({random_x, random_y, random_opcode}) : upd;
`endif
  end

  assign mem_addr    = i_q;
  assign mem_rd_en   = (state_q == READ);
  assign mem_wr_en   = (state_q == WRITE);
  assign mem_wr_data = (state_q == WRITE) ? W'(new_rec) : '0;
  assign busy        = (state_q == READ) || (state_q == LATCH) || (state_q == WRITE);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_coor_update_engine.sv
// Scoreboard bench for coor_update_engine (N=4, OPW=2, DEPTH=4) with a synchronous RAM model.
module tb_coor_update_engine;
  localparam int N = 4, OPW = 2, DEPTH = 4, AW = 2, W = 10;

  logic           clock = 1'b0;
  logic           reset_n, start;
  logic [N-1:0]   step, random_x, random_y;
  logic [OPW-1:0] random_opcode;
  logic [W-1:0]   mem_rd_data;
  logic [AW-1:0]  mem_addr;
  logic           mem_rd_en, mem_wr_en, busy, done;
  logic [W-1:0]   mem_wr_data;
  logic [AW:0]    respawn_cnt;

  coor_update_engine #(.N(N), .OPW(OPW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .step(step),
    .random_x(random_x), .random_y(random_y), .random_opcode(random_opcode),
    .mem_rd_data(mem_rd_data), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .busy(busy),
    .done(done), .respawn_cnt(respawn_cnt)
  );

  always #5 clock = ~clock;

  // RAM model with a bench-side load port
  logic [W-1:0]  mem [DEPTH];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [W-1:0]  ld_data = '0;
  always @(posedge clock) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
  end

  typedef struct packed {logic [AW-1:0] a; logic [W-1:0] d;} wr_t;
  wr_t sb[$];
  int checks = 0, failures = 0, wr_count = 0, done_total = 0;

  function automatic logic [W-1:0] rec(input int x, input int y, input int op);
    return {x[3:0], y[3:0], op[1:0]};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push4(input logic [W-1:0] r0, r1, r2, r3);
    sb.push_back({2'd0, r0}); sb.push_back({2'd1, r1});
    sb.push_back({2'd2, r2}); sb.push_back({2'd3, r3});
  endtask

  task automatic load4(input logic [W-1:0] r0, r1, r2, r3);
    logic [W-1:0] r [4];
    r[0] = r0; r[1] = r1; r[2] = r2; r[3] = r3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock); ld_en = 1'b1; ld_addr = AW'(k); ld_data = r[k];
    end
    @(negedge clock); ld_en = 1'b0;
  endtask

  // monitor: every write strobe pops the next expected {slot, record}
  always @(negedge clock) begin
    wr_t e;
    if (reset_n && mem_wr_en) begin
      wr_count++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%0d data=%h", mem_addr, mem_wr_data);
      end else begin
        e = sb.pop_front();
        if ({mem_addr, mem_wr_data} !== e) begin
          failures++;
          $display("FAIL wr_slot actual=%0d:%h expected=%0d:%h", mem_addr, mem_wr_data, e.a, e.d);
        end
      end
    end
    if (reset_n && done) done_total++;
  end

  task automatic run_pass(input logic [N-1:0] stp, input bit repulse, input int exp_resp);
    int busy_n, done_n, done_at, w0;
    w0 = wr_count; busy_n = 0; done_n = 0; done_at = 0;
    @(negedge clock); step = stp; start = 1'b1;
    @(negedge clock); start = 1'b0; step = ~stp;
    for (int n = 1; n <= 20; n++) begin
      if (n > 1) @(negedge clock);
      if (busy) busy_n++;
      if (done) begin done_n++; done_at = n; end
      start = repulse && (n == 4 || n == 13);
    end
    start = 1'b0;
    check("busy_len", busy_n, 12);
    check("done_count", done_n, 1);
    check("done_cycle", done_at, 13);
    check("write_count", wr_count - w0, 4);
    check("respawn_cnt", int'(respawn_cnt), exp_resp);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    int d0;
    reset_n = 1'b0; start = 1'b0; step = '0;
    random_x = 4'd9; random_y = 4'd4; random_opcode = 2'b10;
    repeat (3) @(negedge clock);
    check("reset_outputs", int'({mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, busy, done, respawn_cnt}), 0);
    reset_n = 1'b1;

    // crossing pattern, start re-pulsed mid-pass and in DONE
    load4(rec(5,7,1), rec(2,9,3), rec(6,14,2), rec(6,0,0));
`ifdef COOR_WRAP_EN
    push4(rec(8,7,1), rec(15,9,3), rec(6,1,2), rec(6,13,0));
    run_pass(4'd3, 1'b1, 0);
`else
    push4(rec(8,7,1), rec(9,4,2), rec(9,4,2), rec(9,4,2));
    run_pass(4'd3, 1'b1, 3);
`endif

    // all four directions, interior moves
    load4(rec(5,5,0), rec(5,5,1), rec(5,5,2), rec(5,5,3));
    push4(rec(5,2,0), rec(8,5,1), rec(5,8,2), rec(2,5,3));
    run_pass(4'd3, 1'b0, 0);

    // moves landing exactly on 0 and 15 do not cross
    load4(rec(3,9,3), rec(12,9,1), rec(9,12,2), rec(9,3,0));
    push4(rec(0,9,3), rec(15,9,1), rec(9,15,2), rec(9,0,0));
    run_pass(4'd3, 1'b0, 0);

    // step 0 rewrites unchanged
    load4(rec(5,7,1), rec(2,9,3), rec(6,14,2), rec(6,0,0));
    push4(rec(5,7,1), rec(2,9,3), rec(6,14,2), rec(6,0,0));
    run_pass(4'd0, 1'b0, 0);

    // reset during the WRITE of slot 1
    load4(rec(5,7,1), rec(2,9,3), rec(6,14,2), rec(6,0,0));
    sb.push_back({2'd0, rec(8,7,1)});
    d0 = done_total;
    @(negedge clock); step = 4'd3; start = 1'b1;
    @(negedge clock); start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (mem_rd_en && mem_addr == 2'd1) found = 1'b1;
      else @(negedge clock);
    end
    check("reach_read1", int'(found), 1);
    @(posedge clock); @(posedge clock); #1;
    check("write1_strobe", int'({mem_wr_en, mem_addr}), 5);
    reset_n = 1'b0; #1;
    check("midreset_outputs", int'({mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, busy, done, respawn_cnt}), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    check("midreset_no_done", done_total - d0, 0);
    check("midreset_sb", sb.size(), 0);
    check("mem0", int'(mem[0]), int'(rec(8,7,1)));
    check("mem1", int'(mem[1]), int'(rec(2,9,3)));
    check("mem2", int'(mem[2]), int'(rec(6,14,2)));
    check("mem3", int'(mem[3]), int'(rec(6,0,0)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
